// File: rtl/register_scoreboard.sv
// Per-register pending-write scoreboard. Issued destinations are claimed here
// and released on writeback; issue stalls while any operand still has a claim.
module reg_pend_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + CNT_W'(1);
    else if (dec_i) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

module register_scoreboard #(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 2,
  parameter int TOTAL_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic                  issue_wb_en,
  input  logic [REG_ADDR_W-1:0] issue_dest,
  input  logic                  issue_single_src,
  input  logic [REG_ADDR_W-1:0] issue_src1,
  input  logic [REG_ADDR_W-1:0] issue_src2,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_dest,
  input  logic                  flush,
  output logic                  hazard_detected,
  output logic                  issue_accept,
  output logic [TOTAL_W-1:0]    busy_count,
  output logic                  err_underflow
);
  localparam int               MAX_BUSY = (NUM_REGS - 1) * ((1 << CNT_W) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
  logic                           src1_busy, src2_busy, dest_sat;
  logic                           inc_req, wb_hit, same_reg;
  logic                           inc_eff, dec_eff, underflow;
  logic [TOTAL_W-1:0]             busy_q, busy_d;
  logic                           err_q;

  // Register 0 has no counter and always reads as idle.
  assign cnt[0] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    reg_pend_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (flush),
      .inc_i (inc_eff && (issue_dest == REG_ADDR_W'(r))),
      .dec_i (dec_eff && (wb_dest == REG_ADDR_W'(r))),
      .cnt_o (cnt[r])
    );
  end

  // Same-cycle writeback is deliberately not forwarded into the hazard check.
  assign src1_busy       = cnt[issue_src1] != '0;
  assign src2_busy       = !issue_single_src && (cnt[issue_src2] != '0);
  assign dest_sat        = issue_wb_en && (issue_dest != '0) && (cnt[issue_dest] == CNT_MAX);
  assign hazard_detected = issue_valid && (src1_busy || src2_busy || dest_sat);
  assign issue_accept    = issue_valid && !hazard_detected && !flush;

  assign inc_req   = issue_accept && issue_wb_en && (issue_dest != '0);
  assign wb_hit    = wb_valid && (wb_dest != '0);
  assign same_reg  = inc_req && wb_hit && (issue_dest == wb_dest);
  assign inc_eff   = inc_req && !same_reg;
  assign dec_eff   = wb_hit && !same_reg && (cnt[wb_dest] != '0);
  assign underflow = wb_hit && !same_reg && (cnt[wb_dest] == '0) && !flush;

  always_comb begin
    busy_d = busy_q;
    if (flush)                   busy_d = '0;
    else if (inc_eff && !dec_eff) busy_d = busy_q + TOTAL_W'(1);
    else if (dec_eff && !inc_eff) busy_d = busy_q - TOTAL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (underflow) err_q <= 1'b1;
    end
  end

  // The total counter must hold every counter saturated at once.
  always_ff @(posedge clk) begin
    if (!rst) assert (MAX_BUSY < (1 << TOTAL_W));
  end

  assign busy_count    = busy_q;
  assign err_underflow = err_q;
endmodule

// File: tb/tb_register_scoreboard.sv
// Directed checks of the register scoreboard with hand-computed expectations.
module tb_register_scoreboard;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       issue_valid = 0, issue_wb_en = 0, issue_single_src = 0;
  logic [4:0] issue_dest = 0, issue_src1 = 0, issue_src2 = 0;
  logic       wb_valid = 0, flush = 0;
  logic [4:0] wb_dest = 0;
  logic       hazard_detected, issue_accept, err_underflow;
  logic [7:0] busy_count;

  int n_chk = 0;
  int n_pass = 0;

  register_scoreboard dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_wb_en(issue_wb_en), .issue_dest(issue_dest),
    .issue_single_src(issue_single_src), .issue_src1(issue_src1), .issue_src2(issue_src2),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .flush(flush),
    .hazard_detected(hazard_detected), .issue_accept(issue_accept),
    .busy_count(busy_count), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic idle();
    issue_valid = 0; issue_wb_en = 0; issue_dest = 0; issue_single_src = 0;
    issue_src1 = 0; issue_src2 = 0; wb_valid = 0; wb_dest = 0; flush = 0;
  endtask

  // Present an instruction; wb/flush are set separately by the caller.
  task automatic iss(input logic wben, input logic [4:0] d, input logic single,
                     input logic [4:0] s1, input logic [4:0] s2);
    issue_valid = 1; issue_wb_en = wben; issue_dest = d;
    issue_single_src = single; issue_src1 = s1; issue_src2 = s2;
  endtask

  task automatic wb(input logic [4:0] d);
    wb_valid = 1; wb_dest = d;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic comb(input string tag, input logic hz, input logic acc);
    #1;
    chk({tag, ".hazard"}, 32'(hazard_detected), 32'(hz));
    chk({tag, ".accept"}, 32'(issue_accept), 32'(acc));
  endtask

  initial begin
    idle();
    rst = 1; tick(); tick(); rst = 0;
    comb("reset", 0, 0);
    chk("reset.busy", 32'(busy_count), 0);
    chk("reset.err", 32'(err_underflow), 0);

    // RAW stall on r5, held through the writeback cycle
    iss(1, 5, 0, 0, 0);     comb("t1.claim", 0, 1);   tick();
    chk("t1.busy1", 32'(busy_count), 1);
    idle(); iss(0, 0, 0, 5, 0); comb("t1.stall", 1, 0); tick();
    wb(5);                  comb("t1.stall_wb", 1, 0); tick();
    chk("t1.busy_after_wb", 32'(busy_count), 0);
    idle(); iss(0, 0, 0, 5, 0); comb("t1.release", 0, 1); tick();
    chk("t1.busy0", 32'(busy_count), 0);

    // Saturation on r7
    idle();
    for (int i = 0; i < 3; i++) begin
      iss(1, 7, 0, 0, 0); comb("t2.fill", 0, 1); tick();
    end
    chk("t2.busy3", 32'(busy_count), 3);
    iss(1, 7, 0, 0, 0); wb(7); comb("t2.sat", 1, 0); tick();
    chk("t2.busy2", 32'(busy_count), 2);
    idle(); iss(1, 7, 0, 0, 0); comb("t2.after_wb", 0, 1); tick();
    chk("t2.busy3b", 32'(busy_count), 3);
    idle();
    for (int i = 0; i < 3; i++) begin wb(7); tick(); end
    idle();
    chk("t2.drain", 32'(busy_count), 0);
    chk("t2.err", 32'(err_underflow), 0);

    // single_src masks src2
    iss(1, 9, 0, 0, 0); comb("t3.claim9", 0, 1); tick();
    idle(); iss(0, 0, 1, 0, 9); comb("t3.single", 0, 1);
    issue_single_src = 0;        comb("t3.dual", 1, 0);
    idle(); wb(9); tick(); idle();
    chk("t3.busy0", 32'(busy_count), 0);

    // Register 0 is never tracked
    for (int i = 0; i < 3; i++) begin
      iss(1, 0, 0, 0, 0); wb(0); comb("t4.r0", 0, 1); tick();
    end
    idle();
    chk("t4.busy", 32'(busy_count), 0);
    chk("t4.err", 32'(err_underflow), 0);

    // Net-zero same-register inc/dec, then real underflow
    iss(1, 4, 0, 0, 0); wb(4); comb("t5.same", 0, 1); tick();
    idle();
    chk("t5.busy", 32'(busy_count), 0);
    chk("t5.err0", 32'(err_underflow), 0);
    iss(0, 0, 0, 4, 0); comb("t5.cnt4_zero", 0, 1);
    idle(); wb(4); tick(); idle();
    chk("t5.err1", 32'(err_underflow), 1);
    chk("t5.busy_uf", 32'(busy_count), 0);
    tick(); tick();
    chk("t5.err_sticky", 32'(err_underflow), 1);

    // Flush overrides a simultaneous issue and keeps err
    iss(1, 2, 0, 0, 0); tick();
    iss(1, 3, 0, 0, 0); tick();
    iss(1, 3, 0, 0, 0); tick();
    idle();
    chk("t6.busy3", 32'(busy_count), 3);
    iss(1, 6, 0, 0, 0); flush = 1; comb("t6.flush", 0, 0); tick();
    idle();
    chk("t6.busy0", 32'(busy_count), 0);
    chk("t6.err_kept", 32'(err_underflow), 1);
    iss(0, 0, 0, 3, 6); comb("t6.clean36", 0, 1);
    iss(0, 0, 0, 2, 0); comb("t6.clean2", 0, 1);

    // Different-register inc and dec in one cycle
    idle(); iss(1, 2, 0, 0, 0); tick();
    iss(1, 3, 0, 0, 0); wb(2); comb("t7.mix", 0, 1); tick();
    idle();
    chk("t7.busy1", 32'(busy_count), 1);
    iss(0, 0, 0, 2, 0); comb("t7.r2_free", 0, 1);
    iss(0, 0, 0, 3, 0); comb("t7.r3_busy", 1, 0);

    // Reset in the middle of a stall
    rst = 1; tick(); rst = 0;
    comb("t8.after_rst", 0, 1);
    chk("t8.busy", 32'(busy_count), 0);
    chk("t8.err", 32'(err_underflow), 0);
    idle(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
